// File: rtl/cdc_4phase_rsp_pkg.sv
// Shared types and helpers for the 4-phase responder endpoint.
package cdc_4phase_rsp_pkg;

    // Transaction FSM states; WAIT_LOW is entered from reset.
    typedef enum logic [2:0] {
        WAIT_LOW  = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_RSP  = 3'd3,
        RSP_SETUP = 3'd4,
        ACK       = 3'd5
    } state_e;

    // Smallest number of synchronizer flops that still resolves metastability.
    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Width needed to hold the values 0..limit (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cdc_4phase_rsp_sync_sr.sv
// Flop-chain synchronizer for a single asynchronous level.
module sync_sr #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous level through the chain; the last flop is safe to use.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/cdc_4phase_rsp.sv
// Responder endpoint: turns an asynchronous 4-phase bundled-data request into
// one local valid/ready request, and returns the local response (or an error
// response after a timeout) qualified by a registered 4-phase acknowledge.
module cdc_4phase_rsp
    import cdc_4phase_rsp_pkg::*;
#(
    parameter type         req_t       = logic,
    parameter type         rsp_t       = logic,
    parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = 256,
    parameter rsp_t        ERR_RSP     = rsp_t'('0)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_req_i,
    input  req_t async_req_data_i,
    output logic async_ack_o,
    output rsp_t async_rsp_data_o,
    output logic async_rsp_err_o,
    output logic req_valid_o,
    input  logic req_ready_i,
    output req_t req_data_o,
    input  logic rsp_valid_i,
    output logic rsp_ready_o,
    input  rsp_t rsp_data_i
);

    localparam int unsigned FW = cnt_width(SYNC_STAGES);

    state_e state_q, state_d;
    logic   req_synced;
    logic   primed;
    logic   timeout_hit;
    logic   ld_req, ld_rsp, ld_err, set_ack, clr_ack, clr_cnt;

    logic [FW-1:0] fill_q;
    logic          ack_q;
    logic          rsp_err_q;
    rsp_t          rsp_data_q;
    req_t          req_data_q;

    sync_sr #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (async_req_i),
        .q_o   (req_synced)
    );

    // After reset the synchronizer holds zeros that were never sampled from the
    // initiator; wait until it has refilled before trusting a low request, so a
    // request held high across reset is not served a second time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= '0;
        end else if (fill_q != FW'(SYNC_STAGES)) begin
            fill_q <= fill_q + FW'(1);
        end
    end

    assign primed = (fill_q == FW'(SYNC_STAGES));

    if (TIMEOUT != 0) begin : g_timeout
        localparam int unsigned CW = cnt_width(TIMEOUT);
        logic [CW-1:0] cnt_q;

        // Count cycles spent waiting for the local response; saturate, never wrap.
        always_ff @(posedge clk_i) begin
            if (rst_i || clr_cnt) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_RSP && cnt_q != CW'(TIMEOUT)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
        logic unused_clr_cnt;
        assign unused_clr_cnt = clr_cnt;
        assign timeout_hit    = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and register load strobes.
    always_comb begin
        state_d = state_q;
        ld_req  = 1'b0;
        ld_rsp  = 1'b0;
        ld_err  = 1'b0;
        set_ack = 1'b0;
        clr_ack = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (primed && !req_synced) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_synced) begin
                    ld_req  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready_i) begin
                    clr_cnt = 1'b1;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A real response in the last timeout cycle takes priority.
                if (rsp_valid_i) begin
                    ld_rsp  = 1'b1;
                    state_d = RSP_SETUP;
                end else if (timeout_hit) begin
                    ld_err  = 1'b1;
                    state_d = RSP_SETUP;
                end
            end
            RSP_SETUP: begin
                // Response data has been stable for a full cycle; raise ack now.
                set_ack = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!req_synced) begin
                    clr_ack = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
    end

    // Payload and acknowledge registers driving the asynchronous and local sides.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= rsp_t'('0);
            req_data_q <= req_t'('0);
        end else begin
            if (ld_req) begin
                req_data_q <= async_req_data_i;
            end
            if (ld_rsp) begin
                rsp_data_q <= rsp_data_i;
                rsp_err_q  <= 1'b0;
            end else if (ld_err) begin
                rsp_data_q <= ERR_RSP;
                rsp_err_q  <= 1'b1;
            end
            if (set_ack) begin
                ack_q <= 1'b1;
            end else if (clr_ack) begin
                ack_q <= 1'b0;
            end
        end
    end

    assign async_ack_o      = ack_q;
    assign async_rsp_data_o = rsp_data_q;
    assign async_rsp_err_o  = rsp_err_q;
    assign req_data_o       = req_data_q;
    assign req_valid_o      = (state_q == ISSUE);
    assign rsp_ready_o      = (state_q == WAIT_RSP);

endmodule
